// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register numbers, ExcCodes, slot_exc bit positions and write masks
package cp0_pkg;
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC = 5'd14;
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP = 5'd9;
  localparam logic [4:0] EXC_RI = 5'd10;
  localparam logic [4:0] EXC_OV = 5'd12;
  localparam int E_ADEL_IF = 0;
  localparam int E_RI = 1;
  localparam int E_BP = 2;
  localparam int E_SYS = 3;
  localparam int E_OV = 4;
  localparam int E_ADEL = 5;
  localparam int E_ADES = 6;
  localparam int E_ERET = 7;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
  localparam logic [31:0] CAUSE_WMASK = 32'h0000_0300;
  localparam logic [31:0] STATUS_RST = 32'h0040_0000;
endpackage

// File: rtl/cp0_exc_arbiter.sv
// cp0_exc_arbiter: picks the oldest faulting slot and its ExcCode, or an ERET
module cp0_exc_arbiter
  import cp0_pkg::*;
#(
  parameter int ISSUE_W = 2,
  parameter int SW = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1
) (
  input  logic [ISSUE_W-1:0]   slot_valid,
  input  logic [8*ISSUE_W-1:0] slot_exc,
  input  logic                 int_pend,
  output logic                 exc_take,
  output logic                 eret_take,
  output logic [SW-1:0]        sel,
  output logic [4:0]           exc_code,
  output logic                 bad_if,
  output logic                 bad_data
);
  logic       found;
  logic [7:0] e;
  logic       intr;
  assign intr = int_pend & slot_valid[0];
  always_comb begin
    found = 1'b0;
    sel = '0;
    e = '0;
    for (int i = ISSUE_W - 1; i >= 0; i--)
      if (slot_valid[i] && |slot_exc[i*8+:8]) begin
        found = 1'b1;
        sel = SW'(i);
        e = slot_exc[i*8+:8];
      end
    if (intr) sel = '0;
    exc_take = intr | (found & |e[6:0]);
    eret_take = ~intr & found & e[E_ERET] & ~|e[6:0];
    exc_code = intr ? EXC_INT :
               e[E_ADEL_IF] ? EXC_ADEL :
               e[E_RI] ? EXC_RI :
               e[E_OV] ? EXC_OV :
               e[E_SYS] ? EXC_SYS :
               e[E_BP] ? EXC_BP :
               e[E_ADEL] ? EXC_ADEL :
               e[E_ADES] ? EXC_ADES : EXC_INT;
    bad_if = ~intr & e[E_ADEL_IF];
    bad_data = ~intr & ~|e[4:0] & |e[6:5];
  end
endmodule

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: multi-issue CP0 registers, timer, precise exception/interrupt/ERET flush
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter int ISSUE_W = 2,
  parameter int HW_INT = 6,
  parameter int COUNT_DIV = 2,
  parameter logic [31:0] EXC_VEC = 32'hbfc00380,
  localparam int SW = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [HW_INT-1:0]     ext_int,
  input  logic [ISSUE_W-1:0]    slot_valid,
  input  logic [8*ISSUE_W-1:0]  slot_exc,
  input  logic [ISSUE_W-1:0]    slot_bd,
  input  logic [32*ISSUE_W-1:0] slot_pc,
  input  logic [32*ISSUE_W-1:0] slot_badaddr,
  input  logic [ISSUE_W-1:0]    mtc0_we,
  input  logic [5*ISSUE_W-1:0]  mtc0_addr,
  input  logic [32*ISSUE_W-1:0] mtc0_wdata,
  input  logic [4:0]            mfc0_addr,
  output logic [31:0]           mfc0_rdata,
  output logic                  flush,
  output logic [31:0]           flush_pc,
  output logic [SW-1:0]         flush_slot,
  output logic                  timer_int
);
  logic [31:0] badvaddr, count, compare, status, cause, epc;
  logic [31:0] badvaddr_nx, count_nx, compare_nx, status_nx, cause_nx, epc_nx;
  logic [3:0]  presc;
  logic        exc_take, eret_take, bad_if, bad_data, int_pend, take, tick, ti_nx;
  logic [SW-1:0] sel;
  logic [4:0]  exc_code;
  logic [31:0] pc_s, bad_s;
  logic        bd_s;
  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic [31:0] wd_count, wd_compare, wd_status, wd_cause, wd_epc;
  logic [5:0]  hw_ip;
  assign int_pend = |(cause[15:8] & status[15:8]) & status[0] & ~status[1];
  cp0_exc_arbiter #(.ISSUE_W(ISSUE_W), .SW(SW)) u_arb (
    .slot_valid(slot_valid),
    .slot_exc(slot_exc),
    .int_pend(int_pend),
    .exc_take(exc_take),
    .eret_take(eret_take),
    .sel(sel),
    .exc_code(exc_code),
    .bad_if(bad_if),
    .bad_data(bad_data)
  );
  assign take = (exc_take | eret_take) & ~rst;
  assign flush = take;
  assign flush_pc = take ? (exc_take ? EXC_VEC : epc) : '0;
  assign flush_slot = take ? sel : '0;
  assign timer_int = cause[30];
  assign mfc0_rdata = (mfc0_addr == REG_BADVADDR) ? badvaddr :
                      (mfc0_addr == REG_COUNT) ? count :
                      (mfc0_addr == REG_COMPARE) ? compare :
                      (mfc0_addr == REG_STATUS) ? status :
                      (mfc0_addr == REG_CAUSE) ? cause :
                      (mfc0_addr == REG_EPC) ? epc : '0;
  always_comb begin
    pc_s = '0;
    bad_s = '0;
    bd_s = 1'b0;
    for (int i = 0; i < ISSUE_W; i++)
      if (sel == SW'(i)) begin
        pc_s = slot_pc[i*32+:32];
        bad_s = slot_badaddr[i*32+:32];
        bd_s = slot_bd[i];
      end
  end
  // Only slots older than the flushing one commit; younger slots overwrite older ones.
  always_comb begin
    {wr_count, wr_compare, wr_status, wr_cause, wr_epc} = '0;
    {wd_count, wd_compare, wd_status, wd_cause, wd_epc} = '0;
    for (int j = 0; j < ISSUE_W; j++)
      if (slot_valid[j] && mtc0_we[j] && !(take && int'(sel) <= j)) begin
        if (mtc0_addr[j*5+:5] == REG_COUNT) begin wr_count = 1'b1; wd_count = mtc0_wdata[j*32+:32]; end
        if (mtc0_addr[j*5+:5] == REG_COMPARE) begin wr_compare = 1'b1; wd_compare = mtc0_wdata[j*32+:32]; end
        if (mtc0_addr[j*5+:5] == REG_STATUS) begin wr_status = 1'b1; wd_status = mtc0_wdata[j*32+:32]; end
        if (mtc0_addr[j*5+:5] == REG_CAUSE) begin wr_cause = 1'b1; wd_cause = mtc0_wdata[j*32+:32]; end
        if (mtc0_addr[j*5+:5] == REG_EPC) begin wr_epc = 1'b1; wd_epc = mtc0_wdata[j*32+:32]; end
      end
  end
  // Exception effects are applied after MTC0 so they win on the same register.
  always_comb begin
    tick = presc == 4'(COUNT_DIV - 1);
    count_nx = wr_count ? wd_count : count + 32'(tick);
    compare_nx = wr_compare ? wd_compare : compare;
    ti_nx = ~wr_compare & (cause[30] | ((tick | wr_count) & (count_nx == compare_nx)));
    hw_ip = 6'(ext_int) | {ti_nx, 5'b0};
    status_nx = wr_status ? (STATUS_RST | (wd_status & STATUS_WMASK)) : status;
    status_nx[1] = exc_take ? 1'b1 : eret_take ? 1'b0 : status_nx[1];
    cause_nx = wr_cause ? ((cause & ~CAUSE_WMASK) | (wd_cause & CAUSE_WMASK)) : cause;
    cause_nx[30] = ti_nx;
    cause_nx[15:10] = hw_ip;
    cause_nx[6:2] = exc_take ? exc_code : cause_nx[6:2];
    cause_nx[31] = (exc_take && !status[1]) ? bd_s : cause_nx[31];
    epc_nx = (exc_take && !status[1]) ? (bd_s ? pc_s - 32'd4 : pc_s) : wr_epc ? wd_epc : epc;
    badvaddr_nx = (exc_take && bad_if) ? pc_s : (exc_take && bad_data) ? bad_s : badvaddr;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      status <= STATUS_RST;
      {badvaddr, count, compare, cause, epc} <= '0;
      presc <= '0;
    end else begin
      status <= status_nx;
      badvaddr <= badvaddr_nx;
      count <= count_nx;
      compare <= compare_nx;
      cause <= cause_nx;
      epc <= epc_nx;
      presc <= (wr_count || tick) ? '0 : presc + 4'd1;
    end
  end
endmodule

// File: tb/tb_cp0_ctrl.sv
// tb_cp0_ctrl: directed checks of CP0 exceptions, timer interrupt, ERET and MTC0 commit rules
module tb_cp0_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic [5:0]  ext_int;
  logic [1:0]  slot_valid, slot_bd, mtc0_we;
  logic [15:0] slot_exc;
  logic [63:0] slot_pc, slot_badaddr, mtc0_wdata;
  logic [9:0]  mtc0_addr;
  logic [4:0]  mfc0_addr;
  logic [31:0] mfc0_rdata, flush_pc;
  logic        flush, timer_int;
  logic [0:0]  flush_slot;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  cp0_ctrl dut (
    .clk(clk), .rst(rst), .ext_int(ext_int), .slot_valid(slot_valid), .slot_exc(slot_exc),
    .slot_bd(slot_bd), .slot_pc(slot_pc), .slot_badaddr(slot_badaddr), .mtc0_we(mtc0_we),
    .mtc0_addr(mtc0_addr), .mtc0_wdata(mtc0_wdata), .mfc0_addr(mfc0_addr),
    .mfc0_rdata(mfc0_rdata), .flush(flush), .flush_pc(flush_pc), .flush_slot(flush_slot),
    .timer_int(timer_int)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    mfc0_addr = a;
    #1;
    chk(tag, mfc0_rdata, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    ext_int = '0; slot_valid = '0; slot_bd = '0; mtc0_we = '0; slot_exc = '0;
    slot_pc = '0; slot_badaddr = '0; mtc0_wdata = '0; mtc0_addr = '0; mfc0_addr = '0;
  endtask
  task automatic clr_exl();
    idle();
    slot_valid = 2'b01; mtc0_we = 2'b01; mtc0_addr = {5'd0, 5'd12}; mtc0_wdata = '0;
    step();
    idle();
  endtask
  initial begin
    idle();
    repeat (2) step();
    #1 chk("rst_flush", flush, 0);
    rd("rst_status", 5'd12, 32'h0040_0000);
    rd("rst_count", 5'd9, 0);
    rd("rst_cause", 5'd13, 0);
    rd("rst_epc", 5'd14, 0);
    rst = 1'b0;
    step();
    // slot0 sys and slot1 ov: the older slot wins
    slot_valid = 2'b11; slot_exc = {8'h10, 8'h08}; slot_pc = {32'h8000_0200, 32'hbfc0_0100};
    #1 chk("t1_flush", flush, 1);
    chk("t1_slot", flush_slot, 0);
    chk("t1_pc", flush_pc, 32'hbfc0_0380);
    step();
    idle();
    rd("t1_cause", 5'd13, 32'h0000_0020);
    rd("t1_epc", 5'd14, 32'hbfc0_0100);
    rd("t1_status", 5'd12, 32'h0040_0002);
    clr_exl();
    rd("clr_status", 5'd12, 32'h0040_0000);
    // slot1 adel_if in a delay slot
    slot_valid = 2'b11; slot_exc = {8'h01, 8'h00}; slot_bd = 2'b10; slot_pc = {32'h8000_1004, 32'h8000_1000};
    #1 chk("t2_slot", flush_slot, 1);
    step();
    idle();
    rd("t2_epc", 5'd14, 32'h8000_1000);
    rd("t2_bad", 5'd8, 32'h8000_1004);
    rd("t2_cause", 5'd13, 32'h8000_0010);
    clr_exl();
    // slot0 MTC0 Status commits ahead of slot1 bp
    slot_valid = 2'b11; slot_exc = {8'h04, 8'h00}; slot_pc = {32'h8000_3000, 32'h8000_2ffc};
    mtc0_we = 2'b01; mtc0_addr = {5'd0, 5'd12}; mtc0_wdata = {32'h0, 32'hffff_ffff};
    #1 chk("t3_slot", flush_slot, 1);
    step();
    idle();
    rd("t3_status", 5'd12, 32'h0040_ff03);
    rd("t3_epc", 5'd14, 32'h8000_3000);
    rd("t3_cause", 5'd13, 32'h0000_0024);
    // slot0 bp with EXL=1 drops the younger MTC0 EPC and holds EPC
    slot_valid = 2'b11; slot_exc = {8'h00, 8'h04}; slot_pc = {32'h8000_4004, 32'h8000_4000};
    mtc0_we = 2'b10; mtc0_addr = {5'd14, 5'd0}; mtc0_wdata = {32'h1234_5678, 32'h0};
    #1 chk("t4_slot", flush_slot, 0);
    step();
    idle();
    rd("t4_epc", 5'd14, 32'h8000_3000);
    // two writes to Compare: the younger slot wins
    slot_valid = 2'b11; mtc0_we = 2'b11; mtc0_addr = {5'd11, 5'd11}; mtc0_wdata = {32'h222, 32'h111};
    #1 chk("t5_noflush", flush, 0);
    step();
    idle();
    rd("t5_compare", 5'd11, 32'h222);
    // ri while EXL=1
    slot_valid = 2'b01; slot_exc = {8'h00, 8'h02}; slot_pc = {32'h0, 32'h9000_0000};
    step();
    idle();
    rd("t6_cause", 5'd13, 32'h0000_0028);
    rd("t6_epc", 5'd14, 32'h8000_3000);
    // ERET redirects to the EPC held before this cycle
    slot_valid = 2'b01; slot_exc = {8'h00, 8'h80};
    #1 chk("t7_flush", flush, 1);
    chk("t7_pc", flush_pc, 32'h8000_3000);
    step();
    idle();
    rd("t7_status", 5'd12, 32'h0040_ff01);
    // timer: Count=0, Compare=5, COUNT_DIV=2
    slot_valid = 2'b11; mtc0_we = 2'b11; mtc0_addr = {5'd11, 5'd9}; mtc0_wdata = {32'd5, 32'd0};
    step();
    idle();
    repeat (9) step();
    chk("t8_ti_early", timer_int, 0);
    step();
    chk("t8_ti", timer_int, 1);
    rd("t8_count", 5'd9, 32'd5);
    chk("t8_wait", flush, 0);
    slot_valid = 2'b01; slot_pc = {32'h0, 32'h8000_2000};
    #1 chk("t8_int_flush", flush, 1);
    chk("t8_int_pc", flush_pc, 32'hbfc0_0380);
    step();
    idle();
    rd("t8_cause", 5'd13, 32'h4000_8000);
    rd("t8_epc", 5'd14, 32'h8000_2000);
    slot_valid = 2'b01; mtc0_we = 2'b01; mtc0_addr = {5'd0, 5'd11}; mtc0_wdata = {32'h0, 32'h100};
    step();
    idle();
    chk("t9_ti_clr", timer_int, 0);
    rd("t9_cause", 5'd13, 32'h0);
    ext_int = 6'b000001;
    step();
    rd("t10_ip2", 5'd13, 32'h0000_0400);
    idle();
    rd("t11_unimpl", 5'd3, 32'h0);
    rd("t11_bad", 5'd8, 32'h8000_1004);
    // reset during an exception cycle
    slot_valid = 2'b01; slot_exc = {8'h00, 8'h08}; rst = 1'b1;
    #1 chk("t12_flush_rst", flush, 0);
    step();
    rd("t12_status", 5'd12, 32'h0040_0000);
    rd("t12_count", 5'd9, 32'h0);
    chk("t12_flush", flush, 0);
    rst = 1'b0;
    idle();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
